// File: rtl/spi_pkg.sv
// Shared constants for the SPI write-frame controller and its register peripheral.
package spi_pkg;

    localparam int unsigned FRAME_W = 16;

    localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY    = 7'h04;
    localparam logic [6:0] REG_MAX_ADDR    = 7'h04;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_HIGH  = 3'd2;
    localparam spi_state_t ST_LOW   = 3'd3;
    localparam spi_state_t ST_GAP   = 3'd4;

    function automatic logic [FRAME_W-1:0] pack_frame(input logic       rw,
                                                      input logic [6:0] addr,
                                                      input logic [7:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/handshake and SPI pin bundle between a host and the spi_controller.
interface spi_controller_if;

    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic       ready;
    logic       done;
    logic       sclk;
    logic       copi;
    logic       ncs;

    modport master (
        output start, rw, addr, data,
        input  ready, done, sclk, copi, ncs
    );

    modport slave (
        input  start, rw, addr, data,
        output ready, done, sclk, copi, ncs
    );

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; o_expire is high on the last cycle of a loaded phase.
module spi_phase_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode 0 initiator: shifts one 16-bit {rw, addr, data} write frame MSB first,
// then holds nCS high for CS_IDLE cycles before signalling done.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5,
    parameter int unsigned CS_IDLE = 4
) (
    input logic             clk,
    input logic             rst,
    spi_controller_if.slave io_spi
);

    localparam int unsigned PhaseMax = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int unsigned PhaseW   = $clog2(PhaseMax);
    localparam logic [PhaseW-1:0] DivLoad = PhaseW'(CLK_DIV - 1);
    localparam logic [PhaseW-1:0] GapLoad = PhaseW'(CS_IDLE - 1);

    if (CLK_DIV < 4 || CS_IDLE < 4) begin : g_param_check
        $error("spi_controller: CLK_DIV and CS_IDLE must both be >= 4");
    end

    spi_state_t         r_state;
    spi_state_t         w_state_d;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] w_shift_d;
    logic [3:0]         r_bit;
    logic [3:0]         w_bit_d;
    logic               w_load;
    logic [PhaseW-1:0]  w_load_val;
    logic               w_expire;
    logic               w_done_d;
    logic               w_active_d;

    logic r_ready;
    logic r_done;
    logic r_sclk;
    logic r_copi;
    logic r_ncs;

    spi_phase_timer #(
        .WIDTH (PhaseW)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_state_d  = r_state;
        w_shift_d  = r_shift;
        w_bit_d    = r_bit;
        w_load     = 1'b0;
        w_load_val = DivLoad;
        w_done_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_spi.start) begin
                    w_state_d = ST_SETUP;
                    w_shift_d = pack_frame(io_spi.rw, io_spi.addr, io_spi.data);
                    w_bit_d   = 4'd15;
                    w_load    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_expire) begin
                    w_state_d = ST_HIGH;
                    w_load    = 1'b1;
                end
            end
            ST_HIGH: begin
                // Shift on the falling edge so COPI gets a full half-period of setup.
                if (w_expire) begin
                    w_state_d = ST_LOW;
                    w_shift_d = {r_shift[FRAME_W-2:0], 1'b0};
                    w_load    = 1'b1;
                end
            end
            ST_LOW: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_bit == 4'd0) begin
                        w_state_d  = ST_GAP;
                        w_load_val = GapLoad;
                    end else begin
                        w_state_d = ST_HIGH;
                        w_bit_d   = r_bit - 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (w_expire) begin
                    w_state_d = ST_IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign w_active_d = (w_state_d == ST_SETUP) || (w_state_d == ST_HIGH) ||
                        (w_state_d == ST_LOW);

    // Pin values are derived from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bit   <= 4'd0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_ncs   <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_bit   <= w_bit_d;
            r_ready <= (w_state_d == ST_IDLE);
            r_done  <= w_done_d;
            r_sclk  <= (w_state_d == ST_HIGH);
            r_copi  <= w_active_d ? w_shift_d[FRAME_W-1] : 1'b0;
            r_ncs   <= ~w_active_d;
        end
    end

    assign io_spi.ready = r_ready;
    assign io_spi.done  = r_done;
    assign io_spi.sclk  = r_sclk;
    assign io_spi.copi  = r_copi;
    assign io_spi.ncs   = r_ncs;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a default instance and a CLK_DIV=4 instance, each
// observed by a small model of the SPI register peripheral.
module tb_spi_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc;
    int   acc2;
    int   d0;
    int   n;

    always #50 clk = ~clk;

    spi_controller_if if_a ();
    spi_controller_if if_b ();

    spi_controller #(.CLK_DIV(5), .CS_IDLE(4)) dut_a (.clk(clk), .rst(rst), .io_spi(if_a));
    spi_controller #(.CLK_DIV(4), .CS_IDLE(4)) dut_b (.clk(clk), .rst(rst), .io_spi(if_b));

    logic [1:0] m_sclk, m_copi, m_ncs, m_done;
    assign m_sclk = {if_b.sclk, if_a.sclk};
    assign m_copi = {if_b.copi, if_a.copi};
    assign m_ncs  = {if_b.ncs, if_a.ncs};
    assign m_done = {if_b.done, if_a.done};

    // Peripheral model state, one slot per instance.
    logic [1:0]  p_sclk = 2'b00;
    logic [1:0]  p_ncs = 2'b11;
    int          rises[2] = '{0, 0};
    int          low_len[2] = '{0, 0};
    int          hi_len[2] = '{0, 0};
    int          last_rises[2] = '{0, 0};
    int          last_low[2] = '{0, 0};
    int          last_gap[2] = '{0, 0};
    int          done_cnt[2] = '{0, 0};
    int          done_cyc[2] = '{0, 0};
    int          frames[2] = '{0, 0};
    logic [15:0] sh[2] = '{16'h0, 16'h0};
    logic [15:0] last_frame[2] = '{16'h0, 16'h0};
    logic [7:0]  regs[2][5] = '{default: 8'h00};

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (m_ncs[i] === 1'b0) begin
                if (p_ncs[i]) begin
                    rises[i]    = 0;
                    low_len[i]  = 0;
                    last_gap[i] = hi_len[i];
                end
                low_len[i]++;
                if (m_sclk[i] && !p_sclk[i]) begin
                    sh[i] = {sh[i][14:0], m_copi[i]};
                    rises[i]++;
                end
            end else begin
                if (!p_ncs[i]) begin
                    last_rises[i] = rises[i];
                    last_low[i]   = low_len[i];
                    last_frame[i] = sh[i];
                    hi_len[i]     = 0;
                    if (rises[i] == 16) begin
                        frames[i]++;
                        if (sh[i][15] && sh[i][14:8] <= 7'h04) regs[i][sh[i][10:8]] = sh[i][7:0];
                    end
                end
                hi_len[i]++;
            end
            if (m_done[i] === 1'b1) begin
                done_cnt[i]++;
                done_cyc[i] = cyc + 1;
            end
            p_sclk[i] = (m_sclk[i] === 1'b1);
            p_ncs[i]  = (m_ncs[i] !== 1'b0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int i, input int base, input int budget);
        int k = 0;
        while (done_cnt[i] == base && k < budget) begin
            tick();
            k++;
        end
        chk(tag, done_cnt[i] - base, 1);
    endtask

    task automatic accept_a(input logic [6:0] a, input logic [7:0] d);
        if_a.start = 1'b1;
        if_a.rw    = 1'b1;
        if_a.addr  = a;
        if_a.data  = d;
        @(posedge clk);
        #1;
        acc = cyc;
        if_a.start = 1'b0;
    endtask

    initial begin
        if_a.start = 1'b0; if_a.rw = 1'b0; if_a.addr = 7'h0; if_a.data = 8'h0;
        if_b.start = 1'b0; if_b.rw = 1'b0; if_b.addr = 7'h0; if_b.data = 8'h0;

        // Reset and idle: {ncs, sclk, copi, ready, done} = 1,0,0,1,0
        repeat (3) tick();
        chk("reset_a", {if_a.ncs, if_a.sclk, if_a.copi, if_a.ready, if_a.done}, 5'b10010);
        chk("reset_b", {if_b.ncs, if_b.sclk, if_b.copi, if_b.ready, if_b.done}, 5'b10010);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_a", {if_a.ncs, if_a.sclk, if_a.copi, if_a.ready, if_a.done}, 5'b10010);
            chk("idle_b", {if_b.ncs, if_b.sclk, if_b.copi, if_b.ready, if_b.done}, 5'b10010);
        end

        // Single frame: duty register write
        tick();
        d0 = done_cnt[0];
        accept_a(7'h04, 8'hA5);
        tick();
        chk("ready_falls", if_a.ready, 1'b0);
        wait_done("single_done", 0, d0, 400);
        chk("single_frame", last_frame[0], 16'h84A5);
        chk("single_rises", last_rises[0], 16);
        chk("single_ncs_low", last_low[0], 165);
        chk("single_done_cyc", done_cyc[0], acc + 170);
        chk("single_duty", regs[0][4], 8'hA5);
        chk("single_ready", if_a.ready, 1'b1);

        // Back-to-back with start held high
        tick();
        d0 = done_cnt[0];
        if_a.start = 1'b1; if_a.rw = 1'b1; if_a.addr = 7'h00; if_a.data = 8'hFF;
        @(posedge clk);
        #1;
        acc = cyc;
        if_a.addr = 7'h02; if_a.data = 8'h0F;
        wait_done("b2b_done1", 0, d0, 400);
        chk("b2b_frame1", last_frame[0], 16'h80FF);
        @(posedge clk);
        #1;
        acc2 = cyc;
        if_a.start = 1'b0;
        chk("b2b_accept_on_done", acc2, done_cyc[0]);
        chk("b2b_period", acc2 - acc, 170);
        wait_done("b2b_done2", 0, d0 + 1, 400);
        chk("b2b_frame2", last_frame[0], 16'h820F);
        chk("b2b_gap", last_gap[0], 5);
        chk("b2b_en_out", regs[0][0], 8'hFF);
        chk("b2b_en_pwm", regs[0][2], 8'h0F);

        // Start pulse during an active frame is ignored
        tick();
        d0 = done_cnt[0];
        n = frames[0];
        accept_a(7'h01, 8'h5A);
        while (cyc < acc + 50) tick();
        chk("busy_not_ready", if_a.ready, 1'b0);
        if_a.start = 1'b1; if_a.addr = 7'h03; if_a.data = 8'h77;
        tick();
        if_a.start = 1'b0;
        wait_done("pulse_done", 0, d0, 400);
        repeat (200) tick();
        chk("pulse_one_done", done_cnt[0] - d0, 1);
        chk("pulse_one_frame", frames[0] - n, 1);
        chk("pulse_rises", last_rises[0], 16);
        chk("pulse_reg1", regs[0][1], 8'h5A);
        chk("pulse_reg3", regs[0][3], 8'h00);

        // Reset after the 8th SCLK rise
        d0 = done_cnt[0];
        accept_a(7'h04, 8'h11);
        n = 0;
        while (!(if_a.ncs === 1'b0 && rises[0] == 8) && n < 200) begin
            tick();
            n++;
        end
        chk("rst_reach_rise8", rises[0], 8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_outputs", {if_a.ncs, if_a.sclk, if_a.copi, if_a.ready, if_a.done}, 5'b10010);
        repeat (20) tick();
        chk("rst_no_done", done_cnt[0] - d0, 0);
        chk("rst_trunc_rises", last_rises[0], 8);
        chk("rst_duty_kept", regs[0][4], 8'hA5);
        accept_a(7'h04, 8'h3C);
        wait_done("rst_after_done", 0, d0, 400);
        chk("rst_after_duty", regs[0][4], 8'h3C);

        // CLK_DIV=4 instance, out-of-range address
        tick();
        if_b.start = 1'b1; if_b.rw = 1'b1; if_b.addr = 7'h7F; if_b.data = 8'h3C;
        @(posedge clk);
        #1;
        acc = cyc;
        if_b.start = 1'b0;
        wait_done("div4_done", 1, 0, 400);
        chk("div4_frame", last_frame[1], 16'hFF3C);
        chk("div4_ncs_low", last_low[1], 132);
        chk("div4_rises", last_rises[1], 16);
        chk("div4_done_cyc", done_cyc[1], acc + 137);
        chk("div4_regs_untouched", {regs[1][0], regs[1][1], regs[1][2], regs[1][3], regs[1][4]}, 40'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
